// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two W-bit operands one N-bit chunk per cycle through an external full adder
module wide_add_sequencer #(
   parameter int N      = 16,
   parameter int CHUNKS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*CHUNKS-1:0] in_a,
   input  logic [N*CHUNKS-1:0] in_b,
   input  logic                in_cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*CHUNKS-1:0] out_sum,
   output logic                out_cout,
   output logic                busy,
   output logic [N-1:0]        add_a,
   output logic [N-1:0]        add_b,
   output logic                add_cin,
   input  logic [N-1:0]        add_sum,
   input  logic                add_cout
);
   localparam int W  = N * CHUNKS;
   localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] idx;
   logic          carry;
   logic [W-1:0]  a_r, b_r;
   logic [31:0]   base;
   logic          last;

   assign base = 32'(idx) * 32'(N);
   assign last = (idx == LAST);

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state, handshake flags and adder drive (adder sees zeros outside RUN)
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      add_a    = '0;
      add_b    = '0;
      add_cin  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            add_a   = a_r[base +: N];
            add_b   = b_r[base +: N];
            add_cin = carry;
            if (last) state_nx = DONE;
         end
         DONE: begin
            busy = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // operand capture, chunk sum collection and carry chaining
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx       <= '0;
         carry     <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r     <= in_a;
               b_r     <= in_b;
               carry   <= in_cin;
               idx     <= '0;
               out_sum <= '0;
            end
            RUN: begin
               out_sum[base +: N] <= add_sum;
               carry              <= add_cout;
               idx                <= last ? '0 : idx + 1'b1;
               if (last) begin
                  out_cout  <= add_cout;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: table-driven and scoreboard checks of the chunked adder sequencer
module tb_wide_add_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   logic        i4_valid, i4_ready, cin4, o4_valid, o4_ready, cout4, busy4;
   logic [63:0] a4, b4, sum4;
   logic [15:0] ad4_a, ad4_b, ad4_sum;
   logic        ad4_cin, ad4_cout;

   logic        i1_valid, i1_ready, cin1, o1_valid, o1_ready, cout1, busy1;
   logic [15:0] a1, b1, sum1;
   logic [15:0] ad1_a, ad1_b, ad1_sum;
   logic        ad1_cin, ad1_cout;

   assign {ad4_cout, ad4_sum} = 17'(ad4_a) + 17'(ad4_b) + 17'(ad4_cin);
   assign {ad1_cout, ad1_sum} = 17'(ad1_a) + 17'(ad1_b) + 17'(ad1_cin);

   wide_add_sequencer #(.N(16), .CHUNKS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(i4_valid), .in_ready(i4_ready),
      .in_a(a4), .in_b(b4), .in_cin(cin4), .out_valid(o4_valid), .out_ready(o4_ready),
      .out_sum(sum4), .out_cout(cout4), .busy(busy4), .add_a(ad4_a), .add_b(ad4_b),
      .add_cin(ad4_cin), .add_sum(ad4_sum), .add_cout(ad4_cout));

   wide_add_sequencer #(.N(16), .CHUNKS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(i1_valid), .in_ready(i1_ready),
      .in_a(a1), .in_b(b1), .in_cin(cin1), .out_valid(o1_valid), .out_ready(o1_ready),
      .out_sum(sum1), .out_cout(cout1), .busy(busy1), .add_a(ad1_a), .add_b(ad1_b),
      .add_cin(ad1_cin), .add_sum(ad1_sum), .add_cout(ad1_cout));

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic [63:0] s;
      logic        co;
   } vec_t;

   vec_t        t4[6];
   vec_t        t1[2];
   logic [15:0] tra[8];
   logic        trc[8];
   int          ntr;
   logic [64:0] q4[$];
   logic [64:0] q1[$];

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errs++;
      $display("FAIL %s", name);
   endtask

   // a reset edge discards any operation in flight
   always @(posedge clk) begin
      if (!rst_n) begin
         q4.delete();
         q1.delete();
      end
   end

   // scoreboard: push the exact sum on acceptance, compare on each delivered result
   always @(negedge clk) begin
      if (rst_n) begin
         if (o4_valid && o4_ready) begin
            if (q4.size() == 0) flag("sb4 unexpected result");
            else chk("sb4", {cout4, sum4}, q4.pop_front());
         end
         if (i4_valid && i4_ready) q4.push_back({1'b0, a4} + {1'b0, b4} + 65'(cin4));
         if (o1_valid && o1_ready) begin
            if (q1.size() == 0) flag("sb1 unexpected result");
            else chk("sb1", 65'({cout1, sum1}), q1.pop_front());
         end
         if (i1_valid && i1_ready) q1.push_back(65'({1'b0, a1} + {1'b0, b1} + 17'(cin1)));
      end
   end

   task automatic accept4(input logic [63:0] a, input logic [63:0] b, input logic c);
      @(posedge clk);
      #1;
      a4 = a; b4 = b; cin4 = c; i4_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i4_ready) break;
      end
      if (!i4_ready) flag("accept4 timeout");
      @(posedge clk);
      #1;
      i4_valid = 1'b0; a4 = ~a; b4 = ~b; cin4 = ~c;
   endtask

   task automatic wait4(output int lat);
      lat = 0;
      ntr = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o4_valid) break;
         if (ntr < 8) begin
            tra[ntr] = ad4_a;
            trc[ntr] = ad4_cin;
            ntr++;
         end
         @(posedge clk);
         lat++;
      end
      if (!o4_valid) flag("wait4 timeout");
   endtask

   task automatic accept1(input logic [15:0] a, input logic [15:0] b, input logic c);
      @(posedge clk);
      #1;
      a1 = a; b1 = b; cin1 = c; i1_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i1_ready) break;
      end
      if (!i1_ready) flag("accept1 timeout");
      @(posedge clk);
      #1;
      i1_valid = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
   endtask

   task automatic wait1(output int lat);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o1_valid) break;
         @(posedge clk);
         lat++;
      end
      if (!o1_valid) flag("wait1 timeout");
   endtask

   initial begin
      int          lat;
      int          seen;
      logic [15:0] ea;
      logic [63:0] hs;
      i4_valid = 0; a4 = '0; b4 = '0; cin4 = 0; o4_ready = 1;
      i1_valid = 0; a1 = '0; b1 = '0; cin1 = 0; o1_ready = 1;
      t4[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
      t4[1] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1};
      t4[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
      t4[3] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
      t4[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};
      t4[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      t1[0] = '{64'h00FF, 64'h0001, 1'b0, 64'h0100, 1'b0};
      t1[1] = '{64'hFFFF, 64'hFFFF, 1'b1, 64'hFFFF, 1'b1};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst in_ready", 65'(i4_ready), 65'd1);
      chk("rst out_valid", 65'(o4_valid), 65'd0);
      chk("rst out_sum", 65'(sum4), 65'd0);
      chk("rst out_cout", 65'(cout4), 65'd0);
      chk("rst busy", 65'(busy4), 65'd0);
      chk("rst adder in", 65'({ad4_a, ad4_b, ad4_cin}), 65'd0);
      chk("rst1 in_ready", 65'(i1_ready), 65'd1);
      chk("rst1 out_valid", 65'(o1_valid), 65'd0);

      for (int i = 0; i < 6; i++) begin
         accept4(t4[i].a, t4[i].b, t4[i].cin);
         wait4(lat);
         chk($sformatf("sum4[%0d]", i), 65'(sum4), 65'(t4[i].s));
         chk($sformatf("cout4[%0d]", i), 65'(cout4), 65'(t4[i].co));
         chk($sformatf("lat4[%0d]", i), 65'(lat), 65'd4);
         chk($sformatf("runlen4[%0d]", i), 65'(ntr), 65'd4);
         if (i == 0)
            for (int k = 0; k < 4; k++) chk($sformatf("add_cin[%0d]", k), 65'(trc[k]), 65'(k != 0));
         if (i == 2)
            for (int k = 0; k < 4; k++) begin
               ea = (k == 3) ? 16'h7FFF : 16'hFFFF;
               chk($sformatf("add_a[%0d]", k), 65'(tra[k]), 65'(ea));
            end
      end

      for (int i = 0; i < 2; i++) begin
         accept1(t1[i].a[15:0], t1[i].b[15:0], t1[i].cin);
         wait1(lat);
         chk($sformatf("sum1[%0d]", i), 65'(sum1), 65'(t1[i].s));
         chk($sformatf("cout1[%0d]", i), 65'(cout1), 65'(t1[i].co));
         chk($sformatf("lat1[%0d]", i), 65'(lat), 65'd1);
      end

      o4_ready = 1'b0;
      accept4(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
      wait4(lat);
      hs = 64'h1234_5678_9ABC_DF00;
      @(posedge clk);
      #1;
      a4 = 64'h8000_0000_0000_0000; b4 = 64'h8000_0000_0000_0000; cin4 = 1'b1; i4_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp in_ready[%0d]", i), 65'(i4_ready), 65'd0);
         chk($sformatf("bp out_valid[%0d]", i), 65'(o4_valid), 65'd1);
         chk($sformatf("bp out_sum[%0d]", i), 65'(sum4), 65'(hs));
         chk($sformatf("bp out_cout[%0d]", i), 65'(cout4), 65'd0);
      end
      @(posedge clk);
      #1 o4_ready = 1'b1;
      @(negedge clk);
      chk("bp ready cycle in_ready", 65'(i4_ready), 65'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp idle in_ready", 65'(i4_ready), 65'd1);
      chk("bp idle busy", 65'(busy4), 65'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp accept busy", 65'(busy4), 65'd1);
      #1;
      i4_valid = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      wait4(lat);
      chk("bp second sum", 65'(sum4), 65'd1);
      chk("bp second cout", 65'(cout4), 65'd1);

      accept4(64'h0003_0002_0001_0000, 64'h0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("midrst idx2 add_a", 65'(ad4_a), 65'h2);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst in_ready", 65'(i4_ready), 65'd1);
      chk("midrst out_valid", 65'(o4_valid), 65'd0);
      chk("midrst out_sum", 65'(sum4), 65'd0);
      chk("midrst out_cout", 65'(cout4), 65'd0);
      chk("midrst busy", 65'(busy4), 65'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (o4_valid) seen++;
      end
      chk("midrst no result", 65'(seen), 65'd0);

      chk("sb4 drained", 65'(q4.size()), 65'd0);
      chk("sb1 drained", 65'(q1.size()), 65'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
